// File: rtl/roe_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// roe_sequencer_pkg
// Shared definitions for the R.O.E. core control path: instruction field
// types, the sequencer state encoding and the default HALT encoding.
// ----------------------------------------------------------------------------
package roe_sequencer_pkg;

    localparam int unsigned INSTR_W = 9;

    // Instruction field types used by decode.
    typedef logic [2:0] op_code_t;
    typedef logic [2:0] func_code_t;

    // Sequencer state encoding (kept as plain constants for legacy tools).
    typedef logic [2:0] seq_state_t;
    localparam seq_state_t IDLE  = 3'd0;
    localparam seq_state_t FETCH = 3'd1;
    localparam seq_state_t EXEC  = 3'd2;
    localparam seq_state_t MEM   = 3'd3;
    localparam seq_state_t HALT  = 3'd4;

    // Instruction encoding that ends a program.
    localparam logic [INSTR_W-1:0] HALT_INSTR_DEFAULT = 9'h1FF;

endpackage

// File: rtl/roe_perf_cnt.sv
// ----------------------------------------------------------------------------
// roe_perf_cnt
// 16-bit saturating event counter.
//   clk    : system clock, rising edge
//   reset  : asynchronous active-high clear
//   inc    : count one event this cycle
//   clr    : synchronous clear (wins over inc)
//   count  : current count, sticks at 16'hFFFF
// ----------------------------------------------------------------------------
module roe_perf_cnt (
    input  logic        clk,
    input  logic        reset,
    input  logic        inc,
    input  logic        clr,
    output logic [15:0] count
);

    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = 16'h0000;
        end else if (inc && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= 16'h0000;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;

endmodule

// File: rtl/roe_sequencer.sv
// ----------------------------------------------------------------------------
// roe_sequencer
// Multi-cycle instruction sequencer: owns pc and ir and steps each
// instruction through FETCH, EXEC and an optional MEM wait. Side effects are
// released by a single commit strobe per retired instruction.
//
// Ports:
//   clk, reset     : clock (rising edge), asynchronous active-high reset
//   start          : pulse, begins execution at START_PC from IDLE or HALT
//   instr          : ROM data at pc (sampled in FETCH)
//   is_mem_op      : decode says ir is a load/store
//   branch_taken   : ALU branch result for ir (used in EXEC)
//   branch_target  : absolute branch destination (used in EXEC)
//   mem_ack        : data memory completed the access (used in MEM)
//   pc, ir         : program counter, instruction register
//   mem_req        : registered data-memory request
//   commit         : retire strobe for reg_write / mem_write
//   busy, done     : in FETCH/EXEC/MEM, in HALT
//   cycle_cnt, retire_cnt : perf counters, only with ROE_SEQ_PERF_EN
//
// Build option: define ROE_SEQ_PERF_EN to add the saturating perf counters.
// ----------------------------------------------------------------------------
module roe_sequencer
    import roe_sequencer_pkg::*;
#(
    parameter int unsigned        PC_W       = 10,
    parameter logic [PC_W-1:0]    START_PC   = '0,
    parameter logic [INSTR_W-1:0] HALT_INSTR = HALT_INSTR_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [INSTR_W-1:0] instr,
    input  logic               is_mem_op,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    input  logic               mem_ack,
    output logic [PC_W-1:0]    pc,
    output logic [INSTR_W-1:0] ir,
    output logic               mem_req,
    output logic               commit,
    output logic               busy,
`ifdef ROE_SEQ_PERF_EN
    output logic [15:0]        cycle_cnt,
    output logic [15:0]        retire_cnt,
`endif
    output logic               done
);

    seq_state_t         state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic               mem_req_q, mem_req_d;
    logic               start_ok;
    logic [PC_W-1:0]    pc_inc;

    // start only counts when the sequencer is not already running.
    assign start_ok = start && ((state_q == IDLE) || (state_q == HALT));
    // Natural wrap modulo 2^PC_W.
    assign pc_inc   = pc_q + PC_W'(1);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        mem_req_d = mem_req_q;
        commit    = 1'b0;
        case (state_q)
            IDLE, HALT: begin
                if (start_ok) begin
                    pc_d    = START_PC;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                ir_d    = instr;
                state_d = EXEC;
            end
            EXEC: begin
                if (ir_q == HALT_INSTR) begin
                    state_d = HALT;
                end else if (is_mem_op) begin
                    mem_req_d = 1'b1;
                    state_d   = MEM;
                end else begin
                    commit  = 1'b1;
                    pc_d    = branch_taken ? branch_target : pc_inc;
                    state_d = FETCH;
                end
            end
            MEM: begin
                if (mem_ack) begin
                    commit    = 1'b1;
                    mem_req_d = 1'b0;
                    pc_d      = pc_inc;
                    state_d   = FETCH;
                end
            end
            default: begin
                mem_req_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            pc_q      <= START_PC;
            ir_q      <= '0;
            mem_req_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            mem_req_q <= mem_req_d;
        end
    end

    assign pc      = pc_q;
    assign ir      = ir_q;
    assign mem_req = mem_req_q;
    assign busy    = (state_q == FETCH) || (state_q == EXEC) || (state_q == MEM);
    assign done    = (state_q == HALT);

`ifdef ROE_SEQ_PERF_EN
    roe_perf_cnt u_cycle_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (busy),
        .clr   (start_ok),
        .count (cycle_cnt)
    );

    roe_perf_cnt u_retire_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (commit),
        .clr   (start_ok),
        .count (retire_cnt)
    );
`endif

endmodule

// File: tb/tb_roe_sequencer.sv
// ----------------------------------------------------------------------------
// tb_roe_sequencer
// Random programs are executed by an instruction-level reference model that
// pushes the expected retire stream (pc, ir, memory wait) into queues; a
// monitor pops and compares on every commit. Programs that end in HALT check
// the halt pc and total busy cycles; programs that do not halt within a cap
// are cut short by an asynchronous reset, preferably mid-MEM.
// ----------------------------------------------------------------------------
module tb_roe_sequencer;

    localparam int unsigned PC_W     = 10;
    localparam logic [9:0]  START_PC = 10'd0;
    localparam logic [8:0]  HALT_I   = 9'h1FF;
    localparam int          CAP      = 40;
    localparam int          N_PROG   = 30;

    logic       clk = 1'b0;
    logic       reset, start, is_mem_op, branch_taken;
    logic       mem_ack = 1'b0;
    logic [8:0] instr, ir;
    logic [9:0] branch_target, pc;
    logic       mem_req, commit, busy, done;
`ifdef ROE_SEQ_PERF_EN
    logic [15:0] cycle_cnt, retire_cnt;
`endif

    logic [8:0] rom [1024];
    logic [9:0] tgt [1024];
    logic       noise_a = 1'b0;
    logic       noise_b = 1'b0;

    int compared   = 0;
    int mismatched = 0;

    typedef struct packed {
        logic [9:0] pc;
        logic [8:0] ir;
        logic       mem;
    } ret_t;

    ret_t exp_q[$];
    int   dly_exp_q[$];
    int   dly_drv_q[$];

    bit tracking = 1'b0;
    bit capped   = 1'b0;
    int busy_cyc = 0;

    initial forever #5 clk = ~clk;

    function automatic logic is_mem(input logic [8:0] i);
        return i[8:7] == 2'b10;
    endfunction

    function automatic logic is_br(input logic [8:0] i);
        return i[8:6] == 3'b110;
    endfunction

    // Environment: ROM, decode and ALU responses. Where the sequencer must
    // ignore a signal, it is driven with noise.
    assign instr         = rom[pc];
    assign branch_target = tgt[pc];
    assign is_mem_op     = is_mem(ir) | ((ir == HALT_I) & noise_b);
    assign branch_taken  = is_br(ir) ? ir[0] :
                           ((is_mem(ir) || (ir == HALT_I)) ? noise_a : 1'b0);

    roe_sequencer #(
        .PC_W       (PC_W),
        .START_PC   (START_PC),
        .HALT_INSTR (HALT_I)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .instr         (instr),
        .is_mem_op     (is_mem_op),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .mem_ack       (mem_ack),
        .pc            (pc),
        .ir            (ir),
        .mem_req       (mem_req),
        .commit        (commit),
        .busy          (busy),
`ifdef ROE_SEQ_PERF_EN
        .cycle_cnt     (cycle_cnt),
        .retire_cnt    (retire_cnt),
`endif
        .done          (done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: walks the program one instruction at a time.
    task automatic run_model(output bit halted, output int cyc, output logic [9:0] hpc,
                             output int nret);
        logic [9:0] p;
        logic [8:0] i;
        int         n;
        ret_t       r;
        p      = START_PC;
        halted = 1'b0;
        cyc    = 0;
        nret   = 0;
        hpc    = '0;
        while (nret < CAP) begin
            i = rom[p];
            cyc += 2;
            if (i == HALT_I) begin
                halted = 1'b1;
                hpc    = p;
                break;
            end
            r.pc = p;
            r.ir = i;
            if (is_mem(i)) begin
                n = $urandom_range(1, 4);
                dly_exp_q.push_back(n);
                dly_drv_q.push_back(n);
                cyc  += n;
                r.mem = 1'b1;
                p     = p + 10'd1;
            end else begin
                r.mem = 1'b0;
                p     = (is_br(i) && i[0]) ? tgt[p] : p + 10'd1;
            end
            exp_q.push_back(r);
            nret++;
        end
    endtask

    // Memory responder: acks after the model-chosen number of MEM cycles,
    // random acks while no request is outstanding.
    initial begin
        int rem;
        bit in_mem;
        rem    = 0;
        in_mem = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            noise_a = 1'($urandom);
            noise_b = 1'($urandom);
            if (reset) begin
                in_mem  = 1'b0;
                mem_ack = 1'b0;
            end else if (mem_req) begin
                if (!in_mem) begin
                    in_mem = 1'b1;
                    rem    = (dly_drv_q.size() > 0) ? dly_drv_q.pop_front() : $urandom_range(1, 4);
                end
                mem_ack = (rem == 1);
                rem--;
            end else begin
                in_mem  = 1'b0;
                mem_ack = 1'($urandom);
            end
        end
    end

    // Monitor: compares every commit against the expected retire stream.
    initial begin
        int   memcnt;
        int   d;
        ret_t e;
        memcnt = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                memcnt = 0;
            end else begin
                if (busy) busy_cyc++;
                memcnt = mem_req ? memcnt + 1 : 0;
                if (commit && tracking) begin
                    if (exp_q.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("FAIL extra_commit: got commit at pc %0h expected none", pc);
                    end else begin
                        e = exp_q.pop_front();
                        check("commit_pc", 32'(pc), 32'(e.pc));
                        check("commit_ir", 32'(ir), 32'(e.ir));
                        check("commit_in_mem", 32'(mem_req), 32'(e.mem));
                        if (e.mem) begin
                            d = (dly_exp_q.size() > 0) ? dly_exp_q.pop_front() : -1;
                            check("mem_wait", 32'(memcnt), 32'(d));
                        end
                        if (capped && (exp_q.size() == 0)) tracking = 1'b0;
                    end
                    check("commit_not_done", 32'(done), 32'd0);
                end
            end
        end
    end

    initial begin
        bit         halted;
        int         exp_cyc, nret, r, cyc;
        logic [9:0] hpc;

        reset = 1'b1;
        start = 1'b0;
        #1;
        check("rst_pc", 32'(pc), 32'(START_PC));
        check("rst_ir", 32'(ir), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_commit", 32'(commit), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int p = 0; p < N_PROG; p++) begin
            for (int a = 0; a < 1024; a++) begin
                r = $urandom_range(0, 99);
                if (r < 10)      rom[a] = HALT_I;
                else if (r < 35) rom[a] = {2'b10, 7'($urandom)};
                else if (r < 60) rom[a] = {3'b110, 6'($urandom)};
                else             rom[a] = {1'b0, 8'($urandom)};
                tgt[a] = ($urandom_range(0, 9) < 4) ? 10'($urandom_range(1020, 1023))
                                                    : 10'($urandom_range(0, 63));
            end
            if (p == 0) begin
                // Endless loop through the top of the address space (pc wrap).
                rom[0]     = 9'h000;
                rom[1]     = 9'h181;
                tgt[1]     = 10'h3FE;
                rom[10'h3FE] = 9'h100;
                rom[10'h3FF] = 9'h002;
            end else if (p == 1) begin
                // Three ALU ops, one memory op, then halt.
                rom[0] = 9'h011;
                rom[1] = 9'h022;
                rom[2] = 9'h033;
                rom[3] = 9'h145;
                rom[4] = HALT_I;
            end

            run_model(halted, exp_cyc, hpc, nret);
            capped   = !halted;
            tracking = 1'b1;

            @(negedge clk);
            start    = 1'b1;
            busy_cyc = 0;
            @(negedge clk);
            start = 1'b0;
            check("start_busy", 32'(busy), 32'd1);
            check("start_done", 32'(done), 32'd0);
            check("start_pc", 32'(pc), 32'(START_PC));

            for (cyc = 0; cyc < 3000; cyc++) begin
                @(negedge clk);
                if (halted ? done : !tracking) break;
                // Stray start pulses while running must be ignored.
                start = busy && ($urandom_range(0, 7) == 0);
            end
            start = 1'b0;
            if (cyc == 3000) begin
                compared++;
                mismatched++;
                $display("FAIL timeout: program %0d got no end, expected one within 3000 cycles", p);
            end

            if (halted) begin
                check("halt_pc", 32'(pc), 32'(hpc));
                check("halt_cycles", 32'(busy_cyc), 32'(exp_cyc));
                check("halt_drained", 32'(exp_q.size()), 32'd0);
                check("halt_mem_req", 32'(mem_req), 32'd0);
                check("halt_commit", 32'(commit), 32'd0);
`ifdef ROE_SEQ_PERF_EN
                check("perf_retire", 32'(retire_cnt), 32'(nret));
                check("perf_cycle", 32'(cycle_cnt), 32'(exp_cyc));
`endif
                @(negedge clk);
                check("halt_hold_done", 32'(done), 32'd1);
                check("halt_hold_pc", 32'(pc), 32'(hpc));
            end else begin
                // Cut the run short with an asynchronous reset, ideally mid-MEM.
                for (int w = 0; w < 30; w++) begin
                    if (mem_req) break;
                    @(negedge clk);
                end
                reset = 1'b1;
                #1;
                check("arst_mem_req", 32'(mem_req), 32'd0);
                check("arst_busy", 32'(busy), 32'd0);
                check("arst_done", 32'(done), 32'd0);
                check("arst_pc", 32'(pc), 32'(START_PC));
                check("arst_ir", 32'(ir), 32'd0);
                check("arst_commit", 32'(commit), 32'd0);
`ifdef ROE_SEQ_PERF_EN
                check("arst_cycle_cnt", 32'(cycle_cnt), 32'd0);
                check("arst_retire_cnt", 32'(retire_cnt), 32'd0);
`endif
                exp_q.delete();
                dly_exp_q.delete();
                dly_drv_q.delete();
                tracking = 1'b0;
                @(negedge clk);
                reset = 1'b0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
